ddr3_init_seq: RTL

DDR3_INIT_SEQ -- requirements
Module: ddr3_init_seq

---
 rtl/ddr3_init_seq.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/ddr3_init_seq.sv
// rtl/ddr3_init_seq.sv - DDR3 power-up init sequencer writing DFII CSRs over Wishbone
// Optional ack watchdog: define DDR3_INIT_ACK_TIMEOUT_EN.
module ddr3_init_seq #(
  parameter logic [31:0] CSR_BASE    = 32'h2400,
  parameter logic [31:0] MR0_VAL     = 32'h220,
  parameter logic [31:0] MR1_VAL     = 32'h6,
  parameter logic [31:0] MR2_VAL     = 32'h200,
  parameter logic [31:0] MR3_VAL     = 32'h0,
  parameter int          RESET_WAIT  = 36,
  parameter int          DLLK_WAIT   = 600,
  parameter int          ZQ_WAIT     = 600,
  parameter int          ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [31:0] wb_adr,
  output logic [31:0] wb_dat_w,
  output logic [3:0]  wb_sel,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  input  logic        wb_ack,
  output logic        ddr_rst_n,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [4:0]  step
);

  typedef enum logic [2:0] {IDLE, RSTW, REQ, GAP, WAITC, DONE, ERR} state_t;

  localparam logic [2:0] OFF_CTRL  = 3'd0;
  localparam logic [2:0] OFF_CMD   = 3'd1;
  localparam logic [2:0] OFF_ISSUE = 3'd2;
  localparam logic [2:0] OFF_ADDR  = 3'd3;
  localparam logic [2:0] OFF_BADDR = 3'd4;

  state_t      state, state_n;
  logic [4:0]  step_q, step_n;
  logic [15:0] cnt, cnt_n;
  logic        dram_rst, dram_rst_nxt;
  logic [4:0]  rel;
  logic [2:0]  grp;
  logic [31:0] mr_val, mr_ba;
  logic [2:0]  tbl_off;
  logic [31:0] tbl_dat;
`ifdef DDR3_INIT_ACK_TIMEOUT_EN
  logic [15:0] wd, wd_n;
`else
  localparam int ack_timeout_unused = ACK_TIMEOUT;
`endif

  // Steps 4..27 are six 4-write groups: addr, baddr, cmd, issue
  always_comb begin
    rel     = step_q - 5'd4;
    grp     = rel[4:2];
    mr_val  = MR0_VAL;
    mr_ba   = 32'd0;
    tbl_off = OFF_CTRL;
    tbl_dat = 32'd0;
    case (grp)
      3'd0:    begin mr_val = MR2_VAL; mr_ba = 32'd2; end
      3'd1:    begin mr_val = MR3_VAL; mr_ba = 32'd3; end
      3'd2:    begin mr_val = MR1_VAL; mr_ba = 32'd1; end
      3'd3:    mr_val = MR0_VAL | 32'h100;
      3'd4:    mr_val = MR0_VAL;
      default: mr_val = 32'h400;
    endcase
    if (step_q < 5'd4) begin
      case (step_q[1:0])
        2'd0:    begin tbl_off = OFF_ADDR;  tbl_dat = 32'd0;  end
        2'd1:    begin tbl_off = OFF_BADDR; tbl_dat = 32'd0;  end
        2'd2:    begin tbl_off = OFF_CTRL;  tbl_dat = 32'h0C; end
        default: begin tbl_off = OFF_CTRL;  tbl_dat = 32'h0E; end
      endcase
    end else if (step_q <= 5'd27) begin
      case (rel[1:0])
        2'd0:    begin tbl_off = OFF_ADDR;  tbl_dat = mr_val; end
        2'd1:    begin tbl_off = OFF_BADDR; tbl_dat = mr_ba;  end
        2'd2:    begin tbl_off = OFF_CMD;   tbl_dat = (grp == 3'd5) ? 32'h03 : 32'h0F; end
        default: begin tbl_off = OFF_ISSUE; tbl_dat = 32'h01; end
      endcase
    end else if (step_q == 5'd28) begin
      tbl_off = OFF_CTRL;
      tbl_dat = 32'h01;
    end
  end

  always_comb begin
    state_n      = state;
    step_n       = step_q;
    cnt_n        = cnt;
    dram_rst_nxt = dram_rst;
`ifdef DDR3_INIT_ACK_TIMEOUT_EN
    wd_n         = 16'd0;
`endif
    case (state)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_n      = RSTW;
          step_n       = 5'd0;
          cnt_n        = 16'(RESET_WAIT);
          dram_rst_nxt = 1'b0;
        end
      end
      RSTW: begin
        // ddr_rst_n releases one cycle before the first request
        if (cnt == 16'd0) begin
          dram_rst_nxt = 1'b1;
          state_n      = REQ;
        end else begin
          cnt_n = cnt - 16'd1;
          if (cnt == 16'd1) dram_rst_nxt = 1'b1;
        end
      end
      REQ: begin
        if (wb_ack) begin
          state_n = GAP;
        end
`ifdef DDR3_INIT_ACK_TIMEOUT_EN
        else if (int'(wd) + 1 >= ACK_TIMEOUT) begin
          state_n = ERR;
        end else begin
          wd_n = wd + 16'd1;
        end
`endif
      end
      GAP: begin
        if (step_q == 5'd23) begin
          cnt_n   = 16'(DLLK_WAIT);
          state_n = WAITC;
        end else if (step_q == 5'd27) begin
          cnt_n   = 16'(ZQ_WAIT);
          state_n = WAITC;
        end else if (step_q == 5'd28) begin
          state_n = DONE;
        end else begin
          step_n  = step_q + 5'd1;
          state_n = REQ;
        end
      end
      WAITC: begin
        if (cnt == 16'd0) begin
          step_n  = step_q + 5'd1;
          state_n = REQ;
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      step_q   <= 5'd0;
      cnt      <= 16'd0;
      dram_rst <= 1'b0;
`ifdef DDR3_INIT_ACK_TIMEOUT_EN
      wd       <= 16'd0;
`endif
    end else begin
      state    <= state_n;
      step_q   <= step_n;
      cnt      <= cnt_n;
      dram_rst <= dram_rst_nxt;
`ifdef DDR3_INIT_ACK_TIMEOUT_EN
      wd       <= wd_n;
`endif
    end
  end

  // Bus outputs decode straight from state so reset clears them without a clock
  assign wb_cyc    = (state == REQ);
  assign wb_stb    = (state == REQ);
  assign wb_we     = (state == REQ);
  assign wb_sel    = (state == REQ) ? 4'hF : 4'h0;
  assign wb_adr    = (state == REQ) ? CSR_BASE + {29'd0, tbl_off} : 32'd0;
  assign wb_dat_w  = (state == REQ) ? tbl_dat : 32'd0;
  assign ddr_rst_n = dram_rst;
  assign busy      = (state == RSTW) || (state == REQ) || (state == GAP) || (state == WAITC);
  assign done      = (state == DONE);
  assign step      = step_q;
`ifdef DDR3_INIT_ACK_TIMEOUT_EN
  assign error     = (state == ERR);
`else
  assign error     = 1'b0;
`endif

endmodule
